// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-level AXI-Stream arbiter.
//   arb_state_t : arbiter FSM state (idle / grant held through TLAST)
//   wrap_inc    : index increment modulo a runtime count (not 2^width)
package axis_arb_pkg;

  localparam int unsigned ARB_NIN_MIN = 2;
  localparam int unsigned ARB_NIN_MAX = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Next index after idx, wrapping from nin-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned nin);
    return (idx + 32'd1 >= nin) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// AXI-Stream bundle of N parallel lanes sharing one data bus layout.
//   tvalid/tready/tlast : one bit per lane
//   tdata               : lane i at [i*DW +: DW]
//   tid                 : stream id of the beat (used on single-lane outputs)
// master drives payload and consumes ready; slave is the mirror.
interface axis_pkt_arbiter_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned DW = 16,
  parameter int unsigned IW = 1
);

  logic [N-1:0]    tvalid;
  logic [N-1:0]    tready;
  logic [N*DW-1:0] tdata;
  logic [N-1:0]    tlast;
  logic [IW-1:0]   tid;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tid,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tid,
    output tready
  );

endinterface

// File: rtl/axis_rr_pick.sv
// Combinational rotate-priority picker: returns the first set request at or
// above ptr, wrapping modulo NIN.
//   req : request vector, bit i = source i
//   ptr : starting index for the search (must be < NIN)
//   idx : winning source index (0 when no request)
//   any : at least one request present
module axis_rr_pick #(
  parameter  int unsigned NIN = 4,
  localparam int unsigned IW  = $clog2(NIN)
) (
  input  logic [NIN-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [IW-1:0]  idx,
  output logic           any
);

  int unsigned cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx  = '0;
    any  = |req;
    cand = 32'd0;
    for (int unsigned off = NIN; off > 0; off--) begin
      cand = 32'(ptr) + off - 32'd1;
      if (cand >= NIN) begin
        cand = cand - NIN;
      end
      if (req[IW'(cand)]) begin
        idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: NIN AXI-Stream inputs share one output.
// A grant is held from the first beat of a packet through its TLAST beat.
//   S_AXI_ACLK   : clock
//   S_AXI_ARESET : synchronous active-high reset
//   s_axis       : NIN input lanes (valid/ready/data/last per lane)
//   m_axis       : single output lane, all payload registered, tid = source
//   o_busy       : grant held
//   o_grant      : current or most recent granted source
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int unsigned NIN = 4,
  parameter  int unsigned DW  = 16,
  localparam int unsigned IW  = $clog2(NIN)
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESET,
  axis_pkt_arbiter_if.slave  s_axis,
  axis_pkt_arbiter_if.master m_axis,
  output logic               o_busy,
  output logic [IW-1:0]      o_grant
);

  arb_state_t     state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;

  logic           m_valid_q, m_valid_d;
  logic [DW-1:0]  m_data_q, m_data_d;
  logic           m_last_q, m_last_d;
  logic [IW-1:0]  m_tid_q, m_tid_d;

  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic           out_free_c;
  logic           accept_c;
  logic [NIN-1:0] s_ready_c;

  // Input-side tid is not part of arbitration.
  logic unused_s_tid;
  assign unused_s_tid = ^s_axis.tid;

  axis_rr_pick #(.NIN(NIN)) u_pick (
    .req (s_axis.tvalid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign out_free_c = !m_valid_q || m_axis.tready[0];

  // Next-state, ready and output-register load logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_tid_d   = m_tid_q;
    s_ready_c = '0;
    accept_c  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        s_ready_c[grant_q] = out_free_c;
        accept_c           = s_axis.tvalid[grant_q] && out_free_c;
        // Release only on an accepted TLAST; a stalled producer keeps the grant.
        if (accept_c && s_axis.tlast[grant_q]) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IW'(wrap_inc(32'(grant_q), NIN));
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (accept_c) begin
      m_valid_d = 1'b1;
      m_data_d  = s_axis.tdata[32'(grant_q)*DW +: DW];
      m_last_d  = s_axis.tlast[grant_q];
      m_tid_d   = grant_q;
    end else if (m_axis.tready[0]) begin
      m_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_tid_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_tid_q   <= m_tid_d;
    end
  end

  assign s_axis.tready = s_ready_c;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tid    = m_tid_q;
  assign o_busy        = (state_q == ARB_LOCKED);
  assign o_grant       = grant_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: a 4-input instance and a 3-input
// instance sharing clock and reset.
module tb_axis_pkt_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axis_pkt_arbiter_if #(.N(4), .DW(16), .IW(2)) s_if ();
  axis_pkt_arbiter_if #(.N(1), .DW(16), .IW(2)) m_if ();
  axis_pkt_arbiter_if #(.N(3), .DW(16), .IW(2)) s3_if ();
  axis_pkt_arbiter_if #(.N(1), .DW(16), .IW(2)) m3_if ();

  logic       busy4, busy3;
  logic [1:0] grant4, grant3;

  axis_pkt_arbiter #(.NIN(4), .DW(16)) u_dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .o_busy       (busy4),
    .o_grant      (grant4)
  );

  axis_pkt_arbiter #(.NIN(3), .DW(16)) u_dut3 (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axis       (s3_if),
    .m_axis       (m3_if),
    .o_busy       (busy3),
    .o_grant      (grant3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output stream for four sources, 2-beat packets, starting at rr_ptr=3.
  logic [1:0]  e4_tid  [10] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
  logic [15:0] e4_data [10] = '{16'h30, 16'h31, 16'h00, 16'h01, 16'h10,
                                16'h11, 16'h20, 16'h21, 16'h32, 16'h33};
  // Expected output for NIN=3, sources 1 and 2, rr_ptr=2, single-beat packets.
  logic [1:0]  e3_tid  [3] = '{2'd2, 2'd1, 2'd2};
  logic [15:0] e3_data [3] = '{16'h20, 16'h10, 16'h21};

  int       beat [4];
  int       budget [4];
  int       nout;
  logic [3:0] acc;

  initial begin
    rst           = 1'b1;
    s_if.tvalid   = '1;
    s_if.tdata    = '0;
    s_if.tlast    = '0;
    s_if.tid      = '0;
    m_if.tready   = 1'b1;
    s3_if.tvalid  = '1;
    s3_if.tdata   = '0;
    s3_if.tlast   = '0;
    s3_if.tid     = '0;
    m3_if.tready  = 1'b1;

    // Reset held three cycles with every source requesting.
    repeat (3) begin
      tick();
      chk("rst_tready4", 32'(s_if.tready), 32'h0);
      chk("rst_mvalid4", 32'(m_if.tvalid), 32'h0);
      chk("rst_tid4",    32'(m_if.tid),    32'h0);
      chk("rst_busy4",   32'(busy4),       32'h0);
      chk("rst_tready3", 32'(s3_if.tready), 32'h0);
      chk("rst_mvalid3", 32'(m3_if.tvalid), 32'h0);
    end
    rst          = 1'b0;
    s_if.tvalid  = '0;
    s3_if.tvalid = '0;
    tick();
    chk("post_rst_mvalid", 32'(m_if.tvalid), 32'h0);
    chk("post_rst_grant",  32'(grant4),      32'h0);
    chk("post_rst_data",   32'(m_if.tdata),  32'h0);

    // Single request: source 2 sends A1, A2, A3.
    s_if.tvalid        = 4'b0100;
    s_if.tdata[32 +: 16] = 16'hA1;
    s_if.tlast         = 4'b0000;
    #1;
    chk("single_idle_tready", 32'(s_if.tready), 32'h0);
    tick();
    chk("single_busy",   32'(busy4),       32'h1);
    chk("single_grant",  32'(grant4),      32'h2);
    chk("single_tready", 32'(s_if.tready), 32'h4);
    chk("single_c1_mvalid", 32'(m_if.tvalid), 32'h0);
    tick();
    chk("single_b0_valid", 32'(m_if.tvalid), 32'h1);
    chk("single_b0_data",  32'(m_if.tdata),  32'hA1);
    chk("single_b0_tid",   32'(m_if.tid),    32'h2);
    chk("single_b0_last",  32'(m_if.tlast),  32'h0);
    s_if.tdata[32 +: 16] = 16'hA2;
    tick();
    chk("single_b1_data",  32'(m_if.tdata),  32'hA2);
    chk("single_b1_last",  32'(m_if.tlast),  32'h0);
    s_if.tdata[32 +: 16] = 16'hA3;
    s_if.tlast           = 4'b0100;
    tick();
    chk("single_b2_data",  32'(m_if.tdata),  32'hA3);
    chk("single_b2_last",  32'(m_if.tlast),  32'h1);
    chk("single_b2_tid",   32'(m_if.tid),    32'h2);
    chk("single_idle_busy", 32'(busy4),      32'h0);
    s_if.tvalid = '0;
    s_if.tlast  = '0;
    #1;
    chk("single_gap_tready", 32'(s_if.tready), 32'h0);
    tick();
    chk("single_drain_mvalid", 32'(m_if.tvalid), 32'h0);

    // All four sources request 2-beat packets; rr_ptr starts at 3 after source 2.
    budget = '{2, 2, 2, 4};
    beat   = '{0, 0, 0, 0};
    nout   = 0;
    for (int cyc = 0; cyc < 60 && nout < 10; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        s_if.tvalid[i]          = (beat[i] < budget[i]);
        s_if.tdata[i*16 +: 16]  = 16'(i*16 + beat[i]);
        s_if.tlast[i]           = beat[i][0];
      end
      #1;
      acc = s_if.tvalid & s_if.tready;
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        chk("rr_tid",  32'(m_if.tid),   32'(e4_tid[nout]));
        chk("rr_data", 32'(m_if.tdata), 32'(e4_data[nout]));
        chk("rr_last", 32'(m_if.tlast), 32'(nout % 2));
        nout++;
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) beat[i]++;
      end
    end
    chk("rr_beat_count", 32'(nout), 32'd10);
    s_if.tvalid = '0;
    s_if.tlast  = '0;
    tick();
    tick();
    chk("rr_done_busy", 32'(busy4), 32'h0);

    // Backpressure mid-packet on source 1 (rr_ptr=0).
    s_if.tvalid          = 4'b0010;
    s_if.tdata[16 +: 16] = 16'hB0;
    tick();
    chk("bp_grant", 32'(grant4), 32'h1);
    tick();
    chk("bp_b0_data", 32'(m_if.tdata), 32'hB0);
    s_if.tdata[16 +: 16] = 16'hB1;
    tick();
    chk("bp_b1_data", 32'(m_if.tdata), 32'hB1);
    s_if.tdata[16 +: 16] = 16'hB2;
    m_if.tready          = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_valid",  32'(m_if.tvalid), 32'h1);
      chk("bp_hold_data",   32'(m_if.tdata),  32'hB1);
      chk("bp_hold_tid",    32'(m_if.tid),    32'h1);
      chk("bp_hold_last",   32'(m_if.tlast),  32'h0);
      chk("bp_hold_tready", 32'(s_if.tready), 32'h0);
      tick();
    end
    m_if.tready = 1'b1;
    #1;
    chk("bp_release_data",   32'(m_if.tdata),  32'hB1);
    chk("bp_release_tready", 32'(s_if.tready), 32'h2);
    tick();
    chk("bp_b2_data", 32'(m_if.tdata), 32'hB2);
    s_if.tdata[16 +: 16] = 16'hB3;
    s_if.tlast           = 4'b0010;
    tick();
    chk("bp_b3_data", 32'(m_if.tdata), 32'hB3);
    chk("bp_b3_last", 32'(m_if.tlast), 32'h1);
    s_if.tvalid = '0;
    s_if.tlast  = '0;
    tick();
    chk("bp_drain_mvalid", 32'(m_if.tvalid), 32'h0);

    // NIN=3: prime rr_ptr to 2 with a one-beat packet from source 1.
    s3_if.tvalid         = 3'b010;
    s3_if.tdata[16 +: 16] = 16'h1F;
    s3_if.tlast          = 3'b010;
    tick();
    chk("n3_prime_grant", 32'(grant3), 32'h1);
    tick();
    chk("n3_prime_tid",  32'(m3_if.tid),   32'h1);
    chk("n3_prime_data", 32'(m3_if.tdata), 32'h1F);
    s3_if.tvalid = '0;
    tick();
    budget = '{0, 1, 2, 0};
    beat   = '{0, 0, 0, 0};
    nout   = 0;
    for (int cyc = 0; cyc < 40 && nout < 3; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        s3_if.tvalid[i]         = (beat[i] < budget[i]);
        s3_if.tdata[i*16 +: 16] = 16'(i*16 + beat[i]);
        s3_if.tlast[i]          = 1'b1;
      end
      #1;
      acc = {1'b0, s3_if.tvalid & s3_if.tready};
      if (m3_if.tvalid[0] && m3_if.tready[0]) begin
        chk("n3_tid",  32'(m3_if.tid),   32'(e3_tid[nout]));
        chk("n3_data", 32'(m3_if.tdata), 32'(e3_data[nout]));
        chk("n3_last", 32'(m3_if.tlast), 32'h1);
        nout++;
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) beat[i]++;
      end
    end
    chk("n3_beat_count", 32'(nout), 32'd3);
    s3_if.tvalid = '0;
    s3_if.tlast  = '0;

    // Reset on the second beat of a 4-beat packet from source 3 (rr_ptr=2).
    s_if.tvalid          = 4'b1000;
    s_if.tdata[48 +: 16] = 16'hC0;
    s_if.tlast           = 4'b0000;
    tick();
    chk("mid_grant", 32'(grant4), 32'h3);
    tick();
    chk("mid_c0_data", 32'(m_if.tdata), 32'hC0);
    s_if.tdata[48 +: 16] = 16'hC1;
    rst                  = 1'b1;
    tick();
    chk("mid_rst_mvalid", 32'(m_if.tvalid), 32'h0);
    chk("mid_rst_data",   32'(m_if.tdata),  32'h0);
    chk("mid_rst_last",   32'(m_if.tlast),  32'h0);
    chk("mid_rst_tid",    32'(m_if.tid),    32'h0);
    chk("mid_rst_busy",   32'(busy4),       32'h0);
    chk("mid_rst_grant",  32'(grant4),      32'h0);
    chk("mid_rst_tready", 32'(s_if.tready), 32'h0);
    rst                  = 1'b0;
    s_if.tvalid          = 4'b1010;
    s_if.tdata[16 +: 16] = 16'hD1;
    s_if.tlast           = 4'b0010;
    #1;
    chk("restart_idle_tready", 32'(s_if.tready), 32'h0);
    tick();
    chk("restart_busy",   32'(busy4),       32'h1);
    chk("restart_grant",  32'(grant4),      32'h1);
    chk("restart_tready", 32'(s_if.tready), 32'h2);
    tick();
    chk("restart_data", 32'(m_if.tdata), 32'hD1);
    chk("restart_tid",  32'(m_if.tid),   32'h1);
    chk("restart_last", 32'(m_if.tlast), 32'h1);
    s_if.tvalid = '0;
    s_if.tlast  = '0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
